// File: rtl/dev_bus_arbiter_pkg.sv
// Shared definitions for the two-master device-bus arbiter: FSM encoding,
// bus widths and the device base addresses used by benches.
package dev_bus_arbiter_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  localparam logic [31:0] DEV0_BASE = 32'h0000_7f00;
  localparam logic [31:0] DEV1_BASE = 32'h0000_7f10;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GNT0  = 3'd1,
    S_GNT1  = 3'd2,
    S_DONE0 = 3'd3,
    S_DONE1 = 3'd4
  } state_e;

  function automatic state_e gnt_state(input logic k);
    return k ? S_GNT1 : S_GNT0;
  endfunction

endpackage

// File: rtl/dev_bus_arbiter_if.sv
// Bundle of both master request ports and the processor-side bridge port.
// 'slave' is the arbiter's view; 'master' is the view of whatever drives it.
interface dev_bus_arbiter_if;
  import dev_bus_arbiter_pkg::*;

  logic  m0_req;
  addr_t m0_addr;
  data_t m0_wd;
  logic  m0_we;
  logic  m0_gnt;
  logic  m0_done;
  data_t m0_rd;

  logic  m1_req;
  addr_t m1_addr;
  data_t m1_wd;
  logic  m1_we;
  logic  m1_gnt;
  logic  m1_done;
  data_t m1_rd;

  addr_t PrAddr;
  data_t PrWD;
  logic  PrWe;
  data_t PrRD;

  modport slave (
    input  m0_req, m0_addr, m0_wd, m0_we,
    input  m1_req, m1_addr, m1_wd, m1_we,
    input  PrRD,
    output m0_gnt, m0_done, m0_rd,
    output m1_gnt, m1_done, m1_rd,
    output PrAddr, PrWD, PrWe
  );

  modport master (
    output m0_req, m0_addr, m0_wd, m0_we,
    output m1_req, m1_addr, m1_wd, m1_we,
    output PrRD,
    input  m0_gnt, m0_done, m0_rd,
    input  m1_gnt, m1_done, m1_rd,
    input  PrAddr, PrWD, PrWe
  );

endinterface

// File: rtl/dev_bus_arbiter_rr_pick_2.sv
// Two-way request picker: fixed priority to M0 or alternate against 'last'.
module rr_pick_2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  input  logic rr_en,
  output logic valid,
  output logic winner
);

  assign valid  = req0 | req1;
  // On a tie, round-robin hands the bus to whoever was not served last.
  assign winner = (req0 & req1) ? (rr_en & ~last) : req1;

endmodule

// File: rtl/dev_bus_arbiter.sv
// Arbitrates the single processor-side device bus between M0 (CPU) and M1
// (debug/DMA): one access per grant, read data captured, one-cycle done.
module dev_bus_arbiter
  import dev_bus_arbiter_pkg::*;
#(
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter logic [31:0] RD_RESET    = 32'h0000_0000
) (
  input logic              clk,
  input logic              reset,
  dev_bus_arbiter_if.slave io_bus
);

  state_e r_state;
  logic   r_last;
  logic   r_gnt0;
  logic   r_gnt1;
  logic   r_done0;
  logic   r_done1;
  data_t  r_m0_rd;
  data_t  r_m1_rd;

  state_e w_state_nxt;
  logic   w_pick_req0;
  logic   w_pick_req1;
  logic   w_pick_valid;
  logic   w_pick_winner;

  // A master's own request is stale during its DONE cycle, so it is masked;
  // the same picker then serves both IDLE and the DONE hand-over.
  assign w_pick_req0 = io_bus.m0_req & (r_state != S_DONE0);
  assign w_pick_req1 = io_bus.m1_req & (r_state != S_DONE1);

  rr_pick_2 u_pick (
    .req0   (w_pick_req0),
    .req1   (w_pick_req1),
    .last   (r_last),
    .rr_en  (ROUND_ROBIN),
    .valid  (w_pick_valid),
    .winner (w_pick_winner)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE, S_DONE0, S_DONE1:
        w_state_nxt = w_pick_valid ? gnt_state(w_pick_winner) : S_IDLE;
      S_GNT0:  w_state_nxt = S_DONE0;
      S_GNT1:  w_state_nxt = S_DONE1;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here samples the pre-edge values of all the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_m0_rd <= RD_RESET;
      r_m1_rd <= RD_RESET;
    end else begin
      r_state <= w_state_nxt;
      r_gnt0  <= (w_state_nxt == S_GNT0);
      r_gnt1  <= (w_state_nxt == S_GNT1);
      r_done0 <= (w_state_nxt == S_DONE0);
      r_done1 <= (w_state_nxt == S_DONE1);
      // Capture happens for writes too; the bridge always returns something.
      case (r_state)
        S_GNT0: begin
          r_m0_rd <= io_bus.PrRD;
          r_last  <= 1'b0;
        end
        S_GNT1: begin
          r_m1_rd <= io_bus.PrRD;
          r_last  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    io_bus.PrAddr = '0;
    io_bus.PrWD   = '0;
    io_bus.PrWe   = 1'b0;
    if (r_gnt0) begin
      io_bus.PrAddr = io_bus.m0_addr;
      io_bus.PrWD   = io_bus.m0_wd;
      io_bus.PrWe   = io_bus.m0_we;
    end else if (r_gnt1) begin
      io_bus.PrAddr = io_bus.m1_addr;
      io_bus.PrWD   = io_bus.m1_wd;
      io_bus.PrWe   = io_bus.m1_we;
    end
  end

  assign io_bus.m0_gnt  = r_gnt0;
  assign io_bus.m1_gnt  = r_gnt1;
  assign io_bus.m0_done = r_done0;
  assign io_bus.m1_done = r_done1;
  assign io_bus.m0_rd   = r_m0_rd;
  assign io_bus.m1_rd   = r_m1_rd;

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Bench for dev_bus_arbiter: a round-robin and a fixed-priority instance see
// the same stimulus; a bus-ownership model predicts outputs and completions.
module tb_dev_bus_arbiter;
  import dev_bus_arbiter_pkg::*;

  typedef struct {
    int          k;
    logic [31:0] rd;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        m0_req, m1_req, m0_we, m1_we;
  logic [29:0] m0_addr, m1_addr;
  logic [31:0] m0_wd, m1_wd;

  int checks = 0;
  int failures = 0;
  bit checking = 1'b0;

  dev_bus_arbiter_if if_rr ();
  dev_bus_arbiter_if if_fp ();

  // Device side: read data is a fixed function of the word address.
  function automatic logic [31:0] dev_rd(input logic [29:0] a);
    if (a == 30'h1fc6) return 32'h1234_5678;
    return {a, 2'b00} ^ 32'h5A5A_0F0F;
  endfunction

  assign if_rr.m0_req = m0_req;   assign if_fp.m0_req = m0_req;
  assign if_rr.m0_addr = m0_addr; assign if_fp.m0_addr = m0_addr;
  assign if_rr.m0_wd = m0_wd;     assign if_fp.m0_wd = m0_wd;
  assign if_rr.m0_we = m0_we;     assign if_fp.m0_we = m0_we;
  assign if_rr.m1_req = m1_req;   assign if_fp.m1_req = m1_req;
  assign if_rr.m1_addr = m1_addr; assign if_fp.m1_addr = m1_addr;
  assign if_rr.m1_wd = m1_wd;     assign if_fp.m1_wd = m1_wd;
  assign if_rr.m1_we = m1_we;     assign if_fp.m1_we = m1_we;
  assign if_rr.PrRD = dev_rd(if_rr.PrAddr);
  assign if_fp.PrRD = dev_rd(if_fp.PrAddr);

  dev_bus_arbiter #(.ROUND_ROBIN(1'b1), .RD_RESET(32'h0000_0000)) u_rr (
    .clk(clk), .reset(reset), .io_bus(if_rr)
  );
  dev_bus_arbiter #(.ROUND_ROBIN(1'b0), .RD_RESET(32'hDEAD_BEEF)) u_fp (
    .clk(clk), .reset(reset), .io_bus(if_fp)
  );

  logic [1:0]  o_gnt [2];
  logic [1:0]  o_done[2];
  logic [29:0] o_addr[2];
  logic [31:0] o_wd  [2];
  logic        o_we  [2];
  logic [31:0] o_rd  [2][2];

  assign o_gnt[0]  = {if_rr.m1_gnt, if_rr.m0_gnt};
  assign o_gnt[1]  = {if_fp.m1_gnt, if_fp.m0_gnt};
  assign o_done[0] = {if_rr.m1_done, if_rr.m0_done};
  assign o_done[1] = {if_fp.m1_done, if_fp.m0_done};
  assign o_addr[0] = if_rr.PrAddr;
  assign o_addr[1] = if_fp.PrAddr;
  assign o_wd[0]   = if_rr.PrWD;
  assign o_wd[1]   = if_fp.PrWD;
  assign o_we[0]   = if_rr.PrWe;
  assign o_we[1]   = if_fp.PrWe;
  assign o_rd[0][0] = if_rr.m0_rd;
  assign o_rd[0][1] = if_rr.m1_rd;
  assign o_rd[1][0] = if_fp.m0_rd;
  assign o_rd[1][1] = if_fp.m1_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: who owns the bus this cycle, who is being told "done",
  // who was served last, and what each master last read.
  string       tag    [2] = '{"rr", "fp"};
  bit          rr_of  [2] = '{1'b1, 1'b0};
  logic [31:0] rd_rst [2] = '{32'h0000_0000, 32'hDEAD_BEEF};
  int          busy   [2] = '{-1, -1};
  int          dn     [2] = '{-1, -1};
  int          lst    [2] = '{1, 1};
  logic [31:0] mrd    [2][2];
  exp_t        q_rr[$];
  exp_t        q_fp[$];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [1:0]  e_gnt, e_done;
      logic [29:0] e_addr;
      logic [31:0] e_wd;
      logic        e_we;
      e_gnt  = {busy[d] == 1, busy[d] == 0};
      e_done = {dn[d] == 1, dn[d] == 0};
      e_addr = (busy[d] == 0) ? m0_addr : (busy[d] == 1) ? m1_addr : 30'h0;
      e_wd   = (busy[d] == 0) ? m0_wd   : (busy[d] == 1) ? m1_wd   : 32'h0;
      e_we   = (busy[d] == 0) ? m0_we   : (busy[d] == 1) ? m1_we   : 1'b0;
      if (checking) begin
        check({tag[d], "_gnt"},    {30'h0, o_gnt[d]},  {30'h0, e_gnt});
        check({tag[d], "_done"},   {30'h0, o_done[d]}, {30'h0, e_done});
        check({tag[d], "_PrAddr"}, {2'b00, o_addr[d]}, {2'b00, e_addr});
        check({tag[d], "_PrWD"},   o_wd[d], e_wd);
        check({tag[d], "_PrWe"},   {31'h0, o_we[d]}, {31'h0, e_we});
        check({tag[d], "_m0_rd"},  o_rd[d][0], mrd[d][0]);
        check({tag[d], "_m1_rd"},  o_rd[d][1], mrd[d][1]);
      end
      if (reset) begin
        busy[d] = -1; dn[d] = -1; lst[d] = 1;
        mrd[d][0] = rd_rst[d]; mrd[d][1] = rd_rst[d];
      end else if (busy[d] >= 0) begin
        exp_t e;
        e.k  = busy[d];
        e.rd = dev_rd(busy[d] == 1 ? m1_addr : m0_addr);
        mrd[d][e.k] = e.rd;
        if (d == 0) q_rr.push_back(e); else q_fp.push_back(e);
        dn[d] = e.k; lst[d] = e.k; busy[d] = -1;
      end else begin
        bit r0, r1;
        r0 = m0_req && (dn[d] != 0);
        r1 = m1_req && (dn[d] != 1);
        if (r0 && r1)  busy[d] = rr_of[d] ? 1 - lst[d] : 0;
        else if (r0)   busy[d] = 0;
        else if (r1)   busy[d] = 1;
        else           busy[d] = -1;
        dn[d] = -1;
      end
    end
  end

  // Scoreboard monitor: every done pulse consumes the oldest predicted access.
  always @(negedge clk) begin
    if (checking) begin
      for (int d = 0; d < 2; d++) begin
        if (o_done[d] != 2'b00) begin
          exp_t e;
          int   k;
          int   n;
          k = o_done[d][1] ? 1 : 0;
          n = (d == 0) ? q_rr.size() : q_fp.size();
          check({tag[d], "_sb_pending"}, {31'h0, n != 0}, 32'h1);
          if (n != 0) begin
            e = (d == 0) ? q_rr.pop_front() : q_fp.pop_front();
            check({tag[d], "_sb_master"}, k, e.k);
            check({tag[d], "_sb_rd"}, o_rd[d][k], e.rd);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] byte_a;
    int cnt0, cnt1;
    reset = 1'b1;
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = '0; m1_addr = '0; m0_wd = '0; m1_wd = '0;
    step(2);
    reset = 1'b0;
    checking = 1'b1;
    step(10);

    // M0 write to DEV0_BASE+4
    byte_a = DEV0_BASE + 32'h4;
    m0_addr = byte_a[31:2]; m0_wd = 32'h0000_000A; m0_we = 1'b1; m0_req = 1'b1;
    step(1);
    @(negedge clk);
    check("wr_gnt",    {31'h0, if_rr.m0_gnt}, 32'h1);
    check("wr_PrWe",   {31'h0, if_rr.PrWe},   32'h1);
    check("wr_PrAddr", {2'b00, if_rr.PrAddr}, 32'h0000_1fc1);
    check("wr_PrWD",   if_rr.PrWD,            32'h0000_000A);
    step(1);
    m0_req = 1'b0; m0_we = 1'b0;
    @(negedge clk);
    check("wr_done",      {31'h0, if_rr.m0_done}, 32'h1);
    check("wr_done_PrWe", {31'h0, if_rr.PrWe},    32'h0);
    step(3);

    // M1 read of DEV1_BASE+8
    byte_a = DEV1_BASE + 32'h8;
    m1_addr = byte_a[31:2]; m1_we = 1'b0; m1_req = 1'b1;
    step(2);
    m1_req = 1'b0;
    @(negedge clk);
    check("rd_done",    {31'h0, if_rr.m1_done}, 32'h1);
    check("rd_m1_rd",   if_rr.m1_rd, 32'h1234_5678);
    check("rd_m0_kept", if_rr.m0_rd, dev_rd(30'h1fc1));
    step(3);

    // Both masters request continuously; round-robin alternates grants.
    m0_addr = 30'h0000_0100; m1_addr = 30'h0000_0200;
    m0_wd = 32'h1111_1111; m1_wd = 32'h2222_2222;
    m0_req = 1'b1; m1_req = 1'b1;
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt0 += int'(if_rr.m0_gnt);
      cnt1 += int'(if_rr.m1_gnt);
    end
    check("rr_gnt0_count", cnt0, 5);
    check("rr_gnt1_count", cnt1, 5);
    step(1);
    m0_req = 1'b0; m1_req = 1'b0;
    step(4);

    // Tie from IDLE after an M0 grant: round-robin picks M1, fixed picks M0.
    m0_req = 1'b1;
    step(1);
    m0_req = 1'b0;
    step(2);
    m0_req = 1'b1; m1_req = 1'b1;
    step(1);
    @(negedge clk);
    check("tie_rr_m1_gnt", {31'h0, if_rr.m1_gnt}, 32'h1);
    check("tie_fp_m0_gnt", {31'h0, if_fp.m0_gnt}, 32'h1);
    step(1);
    m0_req = 1'b0; m1_req = 1'b0;
    step(4);

    // Reset lands in the GNT0 cycle of an M0 write.
    m0_addr = 30'h0000_1fc1; m0_wd = 32'hCAFE_0001; m0_we = 1'b1; m0_req = 1'b1;
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0; m0_req = 1'b0; m0_we = 1'b0;
    @(negedge clk);
    check("rst_gnt_done",  {31'h0, if_rr.m0_done}, 32'h0);
    check("rst_gnt_PrWe",  {31'h0, if_rr.PrWe},    32'h0);
    check("rst_gnt_rd_rr", if_rr.m0_rd, 32'h0000_0000);
    check("rst_gnt_rd_fp", if_fp.m0_rd, 32'hDEAD_BEEF);
    step(3);

    // Random traffic, including cancelled requests and occasional resets.
    for (int i = 0; i < 400; i++) begin
      m0_req  = ($urandom_range(0, 99) < 55);
      m1_req  = ($urandom_range(0, 99) < 55);
      m0_we   = $urandom_range(0, 1) == 1;
      m1_we   = $urandom_range(0, 1) == 1;
      m0_addr = 30'($urandom);
      m1_addr = 30'($urandom);
      m0_wd   = $urandom;
      m1_wd   = $urandom;
      reset   = ($urandom_range(0, 63) == 0);
      step(1);
    end
    m0_req = 1'b0; m1_req = 1'b0; reset = 1'b0;
    step(6);
    check("rr_sb_drained", q_rr.size(), 0);
    check("fp_sb_drained", q_fp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
